aes_round_sequencer: RTL and testbench

- Iterative AES-256 encryption controller. Sequences one 128-bit block through the initial AddRoundKey and 14 rounds of an external single-round combinational datapath.
- Takes the 15 round keys from the key-schedule generator and gates block acceptance until that generator's output has settled after a key load.
- Sits between the block-level valid/ready stream interfaces and the round datapath.

---
 rtl/aes_round_sequencer.sv | 163 ++++++++++++++++
 tb/tb_aes_round_sequencer.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_sequencer.sv
// Iterative AES-256 round sequencer: runs one block through the initial AddRoundKey
// and 14 passes of an external combinational round datapath, gated by key-schedule settling.
module aes_round_sequencer #(
    parameter int unsigned KEY_SETTLE = 16
) (
    input  logic            sys_clk,
    input  logic            sys_rst,
    input  logic            key_load,
    output logic            key_ready,
    input  logic [1919:0]   round_keys,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [127:0]    in_block,
    output logic [127:0]    rnd_state,
    output logic [127:0]    rnd_key,
    output logic            rnd_final,
    output logic [3:0]      rnd_idx,
    input  logic [127:0]    rnd_result,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [127:0]    out_block
);

    typedef enum logic [2:0] {
        NOKEY,
        KEY_WAIT,
        IDLE,
        ROUND,
        DONE
    } FsmState;

    localparam logic [7:0] SETTLE_RELOAD = 8'(KEY_SETTLE - 1);
    localparam logic [3:0] LAST_ROUND    = 4'd14;

    FsmState        fsmState_q, fsmState_d;
    logic [7:0]     settleCnt_q, settleCnt_d;
    logic [3:0]     roundIdx_q, roundIdx_d;
    logic [127:0]   dataState_q, dataState_d;
    logic           keyPend_q, keyPend_d;

    logic [127:0]   roundKeyArr [15];

    // Entry 0 is the initial whitening key, entry 14 the final-round key.
    for (genvar k = 0; k < 15; k++) begin : gen_round_keys
        assign roundKeyArr[k] = round_keys[1919 - 128*k -: 128];
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            fsmState_q  <= NOKEY;
            settleCnt_q <= 8'd0;
            roundIdx_q  <= 4'd0;
            dataState_q <= 128'd0;
            keyPend_q   <= 1'b0;
        end else begin
            fsmState_q  <= fsmState_d;
            settleCnt_q <= settleCnt_d;
            roundIdx_q  <= roundIdx_d;
            dataState_q <= dataState_d;
            keyPend_q   <= keyPend_d;
        end
    end

    always_comb begin
        fsmState_d  = fsmState_q;
        settleCnt_d = settleCnt_q;
        roundIdx_d  = roundIdx_q;
        dataState_d = dataState_q;
        keyPend_d   = keyPend_q;
        case (fsmState_q)
            NOKEY: begin
                if (key_load) begin
                    fsmState_d  = KEY_WAIT;
                    settleCnt_d = SETTLE_RELOAD;
                end
            end
            KEY_WAIT: begin
                if (key_load) begin
                    settleCnt_d = SETTLE_RELOAD;
                end else if (settleCnt_q == 8'd0) begin
                    fsmState_d = IDLE;
                end else begin
                    settleCnt_d = settleCnt_q - 8'd1;
                end
            end
            IDLE: begin
                if (key_load) begin
                    fsmState_d  = KEY_WAIT;
                    settleCnt_d = SETTLE_RELOAD;
                end else if (in_valid) begin
                    dataState_d = in_block ^ roundKeyArr[0];
                    roundIdx_d  = 4'd1;
                    fsmState_d  = ROUND;
                end
            end
            ROUND: begin
                dataState_d = rnd_result;
                if (key_load) begin
                    keyPend_d = 1'b1;
                end
                if (roundIdx_q == LAST_ROUND) begin
                    roundIdx_d = 4'd0;
                    fsmState_d = DONE;
                end else begin
                    roundIdx_d = roundIdx_q + 4'd1;
                end
            end
            DONE: begin
                if (key_load) begin
                    keyPend_d = 1'b1;
                end
                // A key change seen on the handoff edge itself is honoured too.
                if (out_ready) begin
                    if (keyPend_q || key_load) begin
                        fsmState_d  = KEY_WAIT;
                        settleCnt_d = SETTLE_RELOAD;
                        keyPend_d   = 1'b0;
                    end else begin
                        fsmState_d = IDLE;
                    end
                end
            end
            default: begin
                fsmState_d = NOKEY;
            end
        endcase
    end

    always_comb begin
        key_ready = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (fsmState_q)
            IDLE: begin
                key_ready = 1'b1;
                in_ready  = ~key_load;
            end
            ROUND: begin
                key_ready = 1'b1;
            end
            DONE: begin
                key_ready = 1'b1;
                out_valid = 1'b1;
            end
            default: begin
                key_ready = 1'b0;
            end
        endcase
    end

    always_comb begin
        rnd_key = 128'd0;
        if (roundIdx_q != 4'd0 && roundIdx_q <= LAST_ROUND) begin
            rnd_key = roundKeyArr[roundIdx_q];
        end
    end

    assign rnd_state = dataState_q;
    assign out_block = dataState_q;
    assign rnd_idx   = roundIdx_q;
    assign rnd_final = (roundIdx_q == LAST_ROUND);

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Bench for aes_round_sequencer: supplies a reference AES-256 key schedule and round
// datapath, and scores ciphertext, latency, round indexing and key-settle timing.
module tb_aes_round_sequencer;

    localparam int KEY_SETTLE = 16;
    localparam logic [255:0] KEY1 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [255:0] KEY2 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] PT1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT1  = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic           sys_clk;
    logic           sys_rst;
    logic           key_load;
    logic           key_ready;
    logic [1919:0]  round_keys;
    logic           in_valid;
    logic           in_ready;
    logic [127:0]   in_block;
    logic [127:0]   rnd_state;
    logic [127:0]   rnd_key;
    logic           rnd_final;
    logic [3:0]     rnd_idx;
    logic [127:0]   rnd_result;
    logic           out_valid;
    logic           out_ready;
    logic [127:0]   out_block;

    int             testsRun;
    int             failCount;
    int             cycle;
    int             acceptC;
    int             monIdx;
    logic           inFlight;
    logic           prevOv;
    logic [1919:0]  tbKeys;
    logic [127:0]   lastOut;
    logic [127:0]   expQ[$];

    aes_round_sequencer #(.KEY_SETTLE(KEY_SETTLE)) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .key_load   (key_load),
        .key_ready  (key_ready),
        .round_keys (round_keys),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_block   (in_block),
        .rnd_state  (rnd_state),
        .rnd_key    (rnd_key),
        .rnd_final  (rnd_final),
        .rnd_idx    (rnd_idx),
        .rnd_result (rnd_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_block  (out_block)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cycle <= cycle + 1;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = xtime(x);
            y = y >> 1;
        end
        return p;
    endfunction

    // S-box from first principles: multiplicative inverse (a^254) then affine map.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] r = 8'h01;
        logic [7:0] base = a;
        logic [7:0] e = 8'd254;
        logic [7:0] b;
        for (int i = 0; i < 8; i++) begin
            if (e[0]) r = gmul(r, base);
            base = gmul(base, base);
            e = e >> 1;
        end
        b = r;
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] subWord(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [1919:0] keyExpand(input logic [255:0] key);
        logic [31:0]   w [60];
        logic [31:0]   tmp;
        logic [7:0]    rc = 8'h01;
        logic [1919:0] o;
        for (int i = 0; i < 8; i++) w[i] = key[255 - 32*i -: 32];
        for (int i = 8; i < 60; i++) begin
            tmp = w[i-1];
            if (i % 8 == 0) begin
                tmp = subWord({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h000000};
                rc = xtime(rc);
            end else if (i % 8 == 4) begin
                tmp = subWord(tmp);
            end
            w[i] = w[i-8] ^ tmp;
        end
        for (int i = 0; i < 60; i++) o[1919 - 32*i -: 32] = w[i];
        return o;
    endfunction

    function automatic logic [127:0] aesRound(input logic [127:0] st, input logic [127:0] rk, input logic fin);
        logic [7:0]   b [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] o;
        for (int i = 0; i < 16; i++) b[i] = sbox(st[127 - 8*i -: 8]);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                t[4*c + r] = b[4*((c + r) % 4) + r];
        if (!fin) begin
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                t[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                t[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                t[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                t[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
            end
        end
        for (int i = 0; i < 16; i++) o[127 - 8*i -: 8] = t[i];
        return o ^ rk;
    endfunction

    function automatic logic [127:0] aesEncrypt(input logic [127:0] pt, input logic [1919:0] rks);
        logic [127:0] s;
        s = pt ^ rks[1919 -: 128];
        for (int r = 1; r <= 14; r++) s = aesRound(s, rks[1919 - 128*r -: 128], r == 14);
        return s;
    endfunction

    // The external single-round datapath the sequencer drives.
    always_comb rnd_result = aesRound(rnd_state, rnd_key, rnd_final);

    task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
        testsRun++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    // Scoreboard monitor: predicts at acceptance, checks rounds, latency and ciphertext.
    always @(negedge sys_clk) begin
        if (sys_rst) begin
            expQ.delete();
            inFlight = 1'b0;
            prevOv   = 1'b0;
        end else begin
            if (inFlight && (cycle - acceptC) <= 13) begin
                monIdx = cycle - acceptC + 1;
                checkOutput("rnd_idx", 128'(rnd_idx), 128'(monIdx));
                checkOutput("rnd_final", 128'(rnd_final), 128'(monIdx == 14));
                checkOutput("rnd_key", rnd_key, tbKeys[1919 - 128*monIdx -: 128]);
            end
            if (out_valid && !prevOv) begin
                if (!inFlight) checkOutput("spurious out_valid", 128'(out_valid), 128'(0));
                else checkOutput("latency", 128'(cycle - acceptC), 128'(14));
                inFlight = 1'b0;
            end
            if (out_valid && out_ready) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected output", 128'(out_valid), 128'(0));
                end else begin
                    checkOutput("out_block", out_block, expQ.pop_front());
                    lastOut = out_block;
                end
            end
            if (in_valid && in_ready) begin
                expQ.push_back(aesEncrypt(in_block, tbKeys));
                acceptC  = cycle + 1;
                inFlight = 1'b1;
            end
            prevOv = out_valid;
        end
    end

    task automatic applyStimulus(input logic [127:0] blk);
        logic done = 1'b0;
        in_block = blk;
        in_valid = 1'b1;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge sys_clk);
            if (in_ready) begin
                @(posedge sys_clk);
                #1;
                done = 1'b1;
            end
        end
        in_valid = 1'b0;
        if (!done) checkOutput("accept timeout", 128'(in_ready), 128'(1));
    endtask

    task automatic waitOutput();
        int n = 0;
        while (expQ.size() != 0 && n < 100) begin
            @(posedge sys_clk);
            #2;
            n++;
        end
        if (expQ.size() != 0) begin
            checkOutput("output timeout", 128'(expQ.size()), 128'(0));
            expQ.delete();
        end
    endtask

    task automatic waitKeyReady(input int edgeC, input string tag);
        logic seen = 1'b0;
        logic sawInReady = 1'b0;
        int   riseC = 0;
        for (int n = 0; n < 300 && !seen; n++) begin
            @(negedge sys_clk);
            if (key_ready) begin
                seen  = 1'b1;
                riseC = cycle;
            end else if (in_ready) begin
                sawInReady = 1'b1;
            end
        end
        checkOutput({tag, " settle"}, 128'(riseC - edgeC), 128'(KEY_SETTLE));
        checkOutput({tag, " in_ready while settling"}, 128'(sawInReady), 128'(0));
    endtask

    task automatic pulseKeyLoad(input logic [255:0] key, output int edgeC);
        @(posedge sys_clk);
        #1;
        key_load   = 1'b1;
        tbKeys     = keyExpand(key);
        round_keys = tbKeys;
        edgeC      = cycle + 1;
        @(posedge sys_clk);
        #1;
        key_load = 1'b0;
    endtask

    task automatic checkResetState(input string tag);
        @(negedge sys_clk);
        checkOutput({tag, " key_ready"}, 128'(key_ready), 128'(0));
        checkOutput({tag, " in_ready"}, 128'(in_ready), 128'(0));
        checkOutput({tag, " out_valid"}, 128'(out_valid), 128'(0));
        checkOutput({tag, " rnd_idx"}, 128'(rnd_idx), 128'(0));
        checkOutput({tag, " out_block"}, out_block, 128'd0);
        checkOutput({tag, " rnd_key"}, rnd_key, 128'd0);
    endtask

    initial begin
        int          edgeC;
        int          a1;
        int          hEdge;
        logic        sawKeyReady;
        logic        found;
        logic [127:0] blkA;

        testsRun   = 0;
        failCount  = 0;
        cycle      = 0;
        acceptC    = 0;
        inFlight   = 1'b0;
        prevOv     = 1'b0;
        lastOut    = 128'd0;
        sys_rst    = 1'b1;
        key_load   = 1'b0;
        in_valid   = 1'b0;
        in_block   = 128'd0;
        out_ready  = 1'b1;
        tbKeys     = '0;
        round_keys = '0;

        repeat (3) @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;
        checkResetState("reset");

        $display("[TB] key load and settle");
        pulseKeyLoad(KEY1, edgeC);
        waitKeyReady(edgeC, "first key");

        $display("[TB] known-answer block");
        applyStimulus(PT1);
        waitOutput();
        checkOutput("known answer", lastOut, CT1);

        $display("[TB] output backpressure");
        out_ready = 1'b0;
        applyStimulus({$urandom(), $urandom(), $urandom(), $urandom()});
        found = 1'b0;
        for (int n = 0; n < 40 && !found; n++) begin
            @(negedge sys_clk);
            found = out_valid;
        end
        checkOutput("out_valid before hold", 128'(found), 128'(1));
        for (int n = 0; n < 10; n++) begin
            @(negedge sys_clk);
            checkOutput("hold out_valid", 128'(out_valid), 128'(1));
            if (expQ.size() != 0) checkOutput("hold out_block", out_block, expQ[0]);
            checkOutput("hold in_ready", 128'(in_ready), 128'(0));
        end
        @(posedge sys_clk);
        #1;
        out_ready = 1'b1;
        @(posedge sys_clk);
        #1;
        @(negedge sys_clk);
        checkOutput("in_ready after handoff", 128'(in_ready), 128'(1));

        $display("[TB] back-to-back blocks");
        blkA = {$urandom(), $urandom(), $urandom(), $urandom()};
        applyStimulus(blkA);
        a1 = acceptC;
        applyStimulus(~blkA);
        checkOutput("back-to-back spacing", 128'(acceptC - a1), 128'(16));
        waitOutput();

        $display("[TB] key_load mid-block");
        applyStimulus({$urandom(), $urandom(), $urandom(), $urandom()});
        found = 1'b0;
        for (int n = 0; n < 20 && !found; n++) begin
            if (rnd_idx == 4'd7) found = 1'b1;
            else begin
                @(posedge sys_clk);
                #1;
            end
        end
        key_load = 1'b1;
        @(posedge sys_clk);
        #1;
        key_load = 1'b0;
        waitOutput();
        hEdge      = cycle;
        tbKeys     = keyExpand(KEY2);
        round_keys = tbKeys;
        waitKeyReady(hEdge, "pending key");
        applyStimulus({$urandom(), $urandom(), $urandom(), $urandom()});
        waitOutput();

        $display("[TB] key_load with in_valid in IDLE");
        @(posedge sys_clk);
        #1;
        in_block = {$urandom(), $urandom(), $urandom(), $urandom()};
        in_valid = 1'b1;
        key_load = 1'b1;
        edgeC    = cycle + 1;
        @(negedge sys_clk);
        checkOutput("in_ready with key_load", 128'(in_ready), 128'(0));
        @(posedge sys_clk);
        #1;
        in_valid = 1'b0;
        key_load = 1'b0;
        @(negedge sys_clk);
        checkOutput("no accept rnd_idx", 128'(rnd_idx), 128'(0));
        checkOutput("collision key_ready", 128'(key_ready), 128'(0));
        waitKeyReady(edgeC, "collision key");

        $display("[TB] reset mid-block");
        applyStimulus({$urandom(), $urandom(), $urandom(), $urandom()});
        found = 1'b0;
        for (int n = 0; n < 20 && !found; n++) begin
            if (rnd_idx == 4'd5) found = 1'b1;
            else begin
                @(posedge sys_clk);
                #1;
            end
        end
        sys_rst = 1'b1;
        @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;
        checkResetState("mid-block reset");
        sawKeyReady = 1'b0;
        for (int n = 0; n < 30; n++) begin
            @(negedge sys_clk);
            if (key_ready) sawKeyReady = 1'b1;
        end
        checkOutput("stays in NOKEY", 128'(sawKeyReady), 128'(0));
        pulseKeyLoad(KEY1, edgeC);
        waitKeyReady(edgeC, "reload key");
        applyStimulus(PT1);
        waitOutput();
        checkOutput("known answer after reset", lastOut, CT1);

        repeat (3) @(posedge sys_clk);
        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
